// File: rtl/ieu_issue_arb_pkg.sv
// ieu_issue_arb_pkg
// Shared types and widths for the IEU issue arbiter slice.
//   PCYN_OPCODE_WIDTH : decoded opcode width carried with each request
//   IEU_*_W           : payload widths matching the arbiter's default parameters
//   ieu_req_t         : one request as presented to the IEU decode stage
package ieu_issue_arb_pkg;

   localparam int PCYN_OPCODE_WIDTH = 8;
   localparam int IEU_DATA_W        = 32;
   localparam int IEU_ADDR_W        = 32;
   localparam int IEU_ROB_W         = 5;

   typedef struct packed {
      logic [PCYN_OPCODE_WIDTH-1:0] opcode;
      logic [IEU_ADDR_W-1:0]        iaddr;
      logic [IEU_DATA_W-1:0]        insn;
      logic [IEU_DATA_W-1:0]        src_a;
      logic [IEU_DATA_W-1:0]        src_b;
      logic [IEU_ROB_W-1:0]         tag;
   } ieu_req_t;

endpackage

// File: rtl/ieu_issue_arb_if.sv
// ieu_issue_arb_if
// Requester-side bus and IEU-side output bus of the issue arbiter.
//   i_req_*     : per-requester request valid and payload
//   o_req_grant : one-hot grant back to the requesters
//   i_ieu_ready : IEU decode stage accepts the output register
//   o_*         : registered selected request
// Modports: slave = arbiter, master = requesters/IEU side.
interface ieu_issue_arb_if
   import ieu_issue_arb_pkg::*;
#(
   parameter int N   = 2,
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int RW  = 5
) ();

   logic [N-1:0]                          i_req_valid;
   logic [N-1:0][PCYN_OPCODE_WIDTH-1:0]   i_req_opcode;
   logic [N-1:0][AW-1:0]                  i_req_iaddr;
   logic [N-1:0][DW-1:0]                  i_req_insn;
   logic [N-1:0][DW-1:0]                  i_req_src_a;
   logic [N-1:0][DW-1:0]                  i_req_src_b;
   logic [N-1:0][RW-1:0]                  i_req_tag;
   logic [N-1:0]                          o_req_grant;

   logic                                  i_ieu_ready;
   logic [PCYN_OPCODE_WIDTH-1:0]          o_opcode;
   logic [AW-1:0]                         o_iaddr;
   logic [DW-1:0]                         o_insn;
   logic [DW-1:0]                         o_src_a;
   logic [DW-1:0]                         o_src_b;
   logic [RW-1:0]                         o_tag;
   logic                                  o_valid;

   modport slave (
      input  i_req_valid, i_req_opcode, i_req_iaddr, i_req_insn,
             i_req_src_a, i_req_src_b, i_req_tag, i_ieu_ready,
      output o_req_grant, o_opcode, o_iaddr, o_insn, o_src_a, o_src_b,
             o_tag, o_valid
   );

   modport master (
      output i_req_valid, i_req_opcode, i_req_iaddr, i_req_insn,
             i_req_src_a, i_req_src_b, i_req_tag, i_ieu_ready,
      input  o_req_grant, o_opcode, o_iaddr, o_insn, o_src_a, o_src_b,
             o_tag, o_valid
   );

endinterface

// File: rtl/ieu_issue_arb_rr_arb.sv
// ieu_issue_arb_rr_arb
// N-way round-robin pick. The first requester at or after the pointer wins;
// the pointer moves to one past the winner only when a grant is issued.
//   clk, n_rst : clock, synchronous active-low reset
//   i_req      : request vector
//   i_en       : grant enable; with i_en=0 no grant and the pointer holds
//   o_grant    : one-hot grant (combinational)
//   o_ptr      : current priority pointer
module ieu_issue_arb_rr_arb #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic [N-1:0]  i_req,
   input  logic          i_en,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_ptr
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [PW-1:0] idx;
   logic [PW-1:0] nxt;
   logic          found;

   // N is a power of two, so the PW-bit add wraps modulo N for free.
   always_comb begin
      o_grant = '0;
      found   = 1'b0;
      idx     = '0;
      nxt     = ptr_q;
      for (int i = 0; i < N; i++) begin
         idx = ptr_q + PW'(i);
         if (!found && i_req[idx]) begin
            found        = 1'b1;
            o_grant[idx] = i_en;
            nxt          = idx + PW'(1);
         end
      end
      ptr_d = (i_en && found) ? nxt : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign o_ptr = ptr_q;

endmodule

// File: rtl/ieu_issue_arb.sv
// ieu_issue_arb
// Shares one IEU decode stage between several reservation-station
// requesters. One winner per cycle is loaded into a single output register;
// grants are withheld while the IEU stalls, during flush and during reset.
// Build option: PCYN_IEU_ARB_OLDEST_FIRST_EN selects oldest-ROB-tag-first
// arbitration instead of the default round-robin.
//   clk, n_rst : clock, synchronous active-low reset
//   i_flush    : drop the output register, suppress grants this cycle
//   i_rob_head : ROB head index (oldest-first build only)
//   arb        : requester bus / IEU output bus (slave modport)
// The payload register uses ieu_req_t, so the width parameters must stay
// equal to the package widths.
module ieu_issue_arb
   import ieu_issue_arb_pkg::*;
#(
   parameter int OPTN_DATA_WIDTH    = IEU_DATA_W,
   parameter int OPTN_ADDR_WIDTH    = IEU_ADDR_W,
   parameter int OPTN_ROB_IDX_WIDTH = IEU_ROB_W,
   parameter int OPTN_IEU_REQ_NUM   = 2
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          i_flush,
   input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rob_head,
   ieu_issue_arb_if.slave                arb
);

   localparam int N = OPTN_IEU_REQ_NUM;

   logic           o_valid_q;
   logic           o_valid_d;
   ieu_req_t       payload_q;
   ieu_req_t       payload_d;
   ieu_req_t       winner;
   logic           can_load;
   logic           grant_en;
   logic [N-1:0]   grant;

   assign can_load = ~o_valid_q | arb.i_ieu_ready;
   assign grant_en = can_load & ~i_flush & n_rst;

`ifdef PCYN_IEU_ARB_OLDEST_FIRST_EN
   // Age relative to the ROB head; strict compare keeps the lower index on ties.
   logic [OPTN_ROB_IDX_WIDTH-1:0] age;
   logic [OPTN_ROB_IDX_WIDTH-1:0] best_age;
   logic [N-1:0]                  pick;
   logic                          found;

   always_comb begin
      pick     = '0;
      found    = 1'b0;
      best_age = '1;
      age      = '0;
      for (int i = 0; i < N; i++) begin
         age = arb.i_req_tag[i] - i_rob_head;
         if (arb.i_req_valid[i] && (!found || age < best_age)) begin
            found    = 1'b1;
            best_age = age;
            pick     = '0;
            pick[i]  = 1'b1;
         end
      end
      grant = grant_en ? pick : '0;
   end
`else
   logic [((N > 1) ? $clog2(N) : 1)-1:0] rr_ptr;
   logic                                 unused_ok;

   ieu_issue_arb_rr_arb #(.N(N)) u_rr_arb (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_req   (arb.i_req_valid),
      .i_en    (grant_en),
      .o_grant (grant),
      .o_ptr   (rr_ptr)
   );

   assign unused_ok = ^{rr_ptr, i_rob_head};
`endif

   always_comb begin
      winner = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            winner.opcode = arb.i_req_opcode[i];
            winner.iaddr  = arb.i_req_iaddr[i];
            winner.insn   = arb.i_req_insn[i];
            winner.src_a  = arb.i_req_src_a[i];
            winner.src_b  = arb.i_req_src_b[i];
            winner.tag    = arb.i_req_tag[i];
         end
      end
   end

   always_comb begin
      o_valid_d = o_valid_q;
      payload_d = payload_q;
      if (i_flush)       o_valid_d = 1'b0;
      else if (can_load) o_valid_d = |grant;
      if (|grant)        payload_d = winner;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) o_valid_q <= 1'b0;
      else        o_valid_q <= o_valid_d;
   end

   // Payload is don't-care while o_valid=0, so it carries no reset.
   always_ff @(posedge clk) begin
      payload_q <= payload_d;
   end

   assign arb.o_req_grant = grant;
   assign arb.o_valid     = o_valid_q;
   assign arb.o_opcode    = payload_q.opcode;
   assign arb.o_iaddr     = payload_q.iaddr;
   assign arb.o_insn      = payload_q.insn;
   assign arb.o_src_a     = payload_q.src_a;
   assign arb.o_src_b     = payload_q.src_b;
   assign arb.o_tag       = payload_q.tag;

endmodule

// File: tb/tb_ieu_issue_arb.sv
// tb_ieu_issue_arb
// Directed self-checking bench for ieu_issue_arb (2 requesters).
// Inputs change 1 time unit after a rising edge; outputs and the
// combinational grant are sampled 1 unit after that.
module tb_ieu_issue_arb;
   import ieu_issue_arb_pkg::*;

   logic       clk;
   logic       n_rst;
   logic       i_flush;
   logic [4:0] i_rob_head;
   int         n_checks;
   int         n_fail;

   ieu_issue_arb_if #(.N(2), .DW(32), .AW(32), .RW(5)) arb_if ();

   ieu_issue_arb #(
      .OPTN_DATA_WIDTH    (32),
      .OPTN_ADDR_WIDTH    (32),
      .OPTN_ROB_IDX_WIDTH (5),
      .OPTN_IEU_REQ_NUM   (2)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_flush    (i_flush),
      .i_rob_head (i_rob_head),
      .arb        (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; returns 1 unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tags(input logic [4:0] t0, input logic [4:0] t1);
      arb_if.i_req_tag[0] = t0;
      arb_if.i_req_tag[1] = t1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      i_flush = 1'b0;
      i_rob_head = '0;
      arb_if.i_ieu_ready = 1'b1;
      arb_if.i_req_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
         arb_if.i_req_opcode[i] = PCYN_OPCODE_WIDTH'(8'h11 + i);
         arb_if.i_req_iaddr[i]  = 32'h0000_1000 + i;
         arb_if.i_req_insn[i]   = 32'h0BAD_0000 + i;
         arb_if.i_req_src_a[i]  = 32'hA000_0000 + i;
         arb_if.i_req_src_b[i]  = 32'hB000_0000 + i;
      end
      set_tags(5'd3, 5'd7);
      step();
      step();
      #1;
      n_checks++;
      if (arb_if.o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", arb_if.o_valid);
      end
      n_checks++;
      if (arb_if.o_req_grant !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_grant: got %b want 00", arb_if.o_req_grant);
      end
      arb_if.i_req_valid = 2'b00;
      n_rst = 1'b1;
      step();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      logic [4:0] exp_t;
      arb_if.i_req_valid = 2'b11;
      arb_if.i_ieu_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_t = (i % 2 == 0) ? 5'd3 : 5'd7;
         #1;
         n_checks++;
         if (arb_if.o_req_grant !== exp_g) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: got %b want %b", i, arb_if.o_req_grant, exp_g);
         end
         step();
         n_checks++;
         if (arb_if.o_valid !== 1'b1 || arb_if.o_tag !== exp_t) begin
            n_fail++;
            $display("FAIL rr_out[%0d]: got valid=%b tag=%0d want valid=1 tag=%0d",
                     i, arb_if.o_valid, arb_if.o_tag, exp_t);
         end
         if (i == 0) begin
            n_checks++;
            if (arb_if.o_src_a !== 32'hA000_0000 || arb_if.o_src_b !== 32'hB000_0000 ||
                arb_if.o_opcode !== 8'h11 || arb_if.o_iaddr !== 32'h0000_1000 ||
                arb_if.o_insn !== 32'h0BAD_0000) begin
               n_fail++;
               $display("FAIL rr_payload: got op=%h ia=%h in=%h a=%h b=%h want op=11 ia=00001000 in=0bad0000 a=a0000000 b=b0000000",
                        arb_if.o_opcode, arb_if.o_iaddr, arb_if.o_insn, arb_if.o_src_a, arb_if.o_src_b);
            end
         end
      end
   endtask

   // Entry: o_valid=1 holding req1 (tag 7), pointer at 0.
   task automatic test_backpressure();
      arb_if.i_ieu_ready = 1'b0;
      arb_if.i_req_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (arb_if.o_req_grant !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_grant[%0d]: got %b want 00", i, arb_if.o_req_grant);
         end
         step();
         n_checks++;
         if (arb_if.o_valid !== 1'b1 || arb_if.o_tag !== 5'd7 || arb_if.o_src_a !== 32'hA000_0001) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got valid=%b tag=%0d a=%h want valid=1 tag=7 a=a0000001",
                     i, arb_if.o_valid, arb_if.o_tag, arb_if.o_src_a);
         end
      end
      arb_if.i_ieu_ready = 1'b1;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b01) begin
         n_fail++;
         $display("FAIL stall_release_grant: got %b want 01", arb_if.o_req_grant);
      end
      step();
      n_checks++;
      if (arb_if.o_valid !== 1'b1 || arb_if.o_tag !== 5'd3) begin
         n_fail++;
         $display("FAIL stall_release_out: got valid=%b tag=%0d want valid=1 tag=3",
                  arb_if.o_valid, arb_if.o_tag);
      end
   endtask

   // Entry: o_valid=1, pointer at 1.
   task automatic test_flush();
      arb_if.i_req_valid = 2'b01;
      i_flush = 1'b1;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_grant: got %b want 00", arb_if.o_req_grant);
      end
      step();
      i_flush = 1'b0;
      n_checks++;
      if (arb_if.o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_valid: got %b want 0", arb_if.o_valid);
      end
      arb_if.i_req_valid = 2'b11;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b10) begin
         n_fail++;
         $display("FAIL flush_ptr_kept: got %b want 10", arb_if.o_req_grant);
      end
      step();
      n_checks++;
      if (arb_if.o_valid !== 1'b1 || arb_if.o_tag !== 5'd7) begin
         n_fail++;
         $display("FAIL flush_after_out: got valid=%b tag=%0d want valid=1 tag=7",
                  arb_if.o_valid, arb_if.o_tag);
      end
   endtask

   // Entry: pointer at 0.
   task automatic test_wrap();
      arb_if.i_req_valid = 2'b10;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b10) begin
         n_fail++;
         $display("FAIL wrap_only_req1: got %b want 10", arb_if.o_req_grant);
      end
      step();
      arb_if.i_req_valid = 2'b11;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b01) begin
         n_fail++;
         $display("FAIL wrap_ptr_zero: got %b want 01", arb_if.o_req_grant);
      end
      step();
      arb_if.i_req_valid = 2'b01;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b01) begin
         n_fail++;
         $display("FAIL wrap_only_req0: got %b want 01", arb_if.o_req_grant);
      end
      step();
      arb_if.i_req_valid = 2'b00;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_grant: got %b want 00", arb_if.o_req_grant);
      end
      step();
      n_checks++;
      if (arb_if.o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_valid: got %b want 0", arb_if.o_valid);
      end
   endtask

   task automatic test_oldest_first();
      arb_if.i_ieu_ready = 1'b1;
      arb_if.i_req_valid = 2'b11;
      i_rob_head = 5'd30;
      set_tags(5'd2, 5'd31);
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b10) begin
         n_fail++;
         $display("FAIL oldest_age: got %b want 10", arb_if.o_req_grant);
      end
      step();
      n_checks++;
      if (arb_if.o_tag !== 5'd31 || arb_if.o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL oldest_out: got valid=%b tag=%0d want valid=1 tag=31",
                  arb_if.o_valid, arb_if.o_tag);
      end
      set_tags(5'd5, 5'd5);
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b01) begin
         n_fail++;
         $display("FAIL oldest_tie: got %b want 01", arb_if.o_req_grant);
      end
      step();
      i_rob_head = '0;
      set_tags(5'd3, 5'd7);
   endtask

   // Entry: pointer at 1 (round-robin build); o_valid becomes 1 before reset.
   task automatic test_reset_mid();
      arb_if.i_ieu_ready = 1'b1;
      arb_if.i_req_valid = 2'b01;
      step();
      n_checks++;
      if (arb_if.o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pre_valid: got %b want 1", arb_if.o_valid);
      end
      arb_if.i_req_valid = 2'b11;
      n_rst = 1'b0;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_grant: got %b want 00", arb_if.o_req_grant);
      end
      step();
      n_checks++;
      if (arb_if.o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_valid: got %b want 0", arb_if.o_valid);
      end
      n_rst = 1'b1;
      #1;
      n_checks++;
      if (arb_if.o_req_grant !== 2'b01) begin
         n_fail++;
         $display("FAIL rstmid_first_grant: got %b want 01", arb_if.o_req_grant);
      end
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
`ifdef PCYN_IEU_ARB_OLDEST_FIRST_EN
      test_oldest_first();
`else
      test_round_robin();
      test_backpressure();
      test_flush();
      test_wrap();
      test_reset_mid();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
